// File: rtl/proc_pkg.sv
// Shared types for processor_param: opcode and state encodings plus field-offset helpers.
// No logic, no latency, no backpressure.
// Offsets are functions because the package cannot see the instantiating module's DW/RW.
package proc_pkg;

    localparam int PROC_DW = 9;
    localparam int PROC_RW = 3;

    typedef enum logic [2:0] {
        MV   = 3'b000,
        MVI  = 3'b001,
        ADD  = 3'b010,
        SUB  = 3'b011,
        AND  = 3'b100,
        XOR  = 3'b101,
        MVNZ = 3'b110,
        RSVD = 3'b111
    } opcode_t;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    function automatic int op_lsb(input int dw);
        return dw - 3;
    endfunction

    function automatic int x_lsb(input int dw, input int rw);
        return dw - 3 - rw;
    endfunction

    function automatic int y_lsb(input int dw, input int rw);
        return dw - 3 - 2 * rw;
    endfunction

    function automatic logic is_alu(input opcode_t op);
        return (op == ADD) || (op == SUB) || (op == AND) || (op == XOR);
    endfunction

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU: add/sub/and/xor of a and b, modulo 2**DW, with zero indication.
// Latency: zero cycles (pure combinational).
// Backpressure: none; result is valid whenever inputs are.
module proc_alu
    import proc_pkg::*;
#(
    parameter int DW = 9
) (
    input  logic [2:0]    op,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] result,
    output logic          zero
);

    always_comb begin
        result = '0;
        case (opcode_t'(op))
            ADD:     result = a + b;
            SUB:     result = a - b;
            AND:     result = a & b;
            XOR:     result = a ^ b;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/processor_param.sv
// Multi-cycle accumulator processor (register file, shared bus, ALU); opcode 110 is mvnz when PROC_MVNZ_EN is defined.
// Latency: fetch + 1 cycle for mv/mvi/mvnz/reserved, fetch + 3 cycles for ALU ops; Done marks the final cycle.
// Backpressure: Run is only sampled in T0; there is no stall once an instruction is fetched.
module processor_param
    import proc_pkg::*;
#(
    parameter int DW = PROC_DW,
    parameter int RW = PROC_RW
) (
    input  logic          clock,
    input  logic          aResetn,
    input  logic          Run,
    input  logic [DW-1:0] DIN,
    output logic          Done,
    output logic [DW-1:0] BusWires
);

    localparam int NREG   = 2 ** RW;
    localparam int OP_LSB = op_lsb(DW);
    localparam int X_LSB  = x_lsb(DW, RW);
    localparam int Y_LSB  = y_lsb(DW, RW);

    state_t        state;
    logic [DW-1:0] ir;
    logic [DW-1:0] a_reg;
    logic [DW-1:0] g_reg;
    logic          z_flag;
    logic [DW-1:0] regs [NREG];

    opcode_t       op;
    logic [RW-1:0] rx;
    logic [RW-1:0] ry;

    logic          rx_wr;
    logic          a_ld;
    logic          g_ld;
    logic [DW-1:0] alu_res;
    logic          alu_zero;

    assign op = opcode_t'(ir[OP_LSB +: 3]);
    assign rx = ir[X_LSB +: RW];
    assign ry = ir[Y_LSB +: RW];

    proc_alu #(.DW(DW)) u_alu (
        .op     (ir[OP_LSB +: 3]),
        .a      (a_reg),
        .b      (BusWires),
        .result (alu_res),
        .zero   (alu_zero)
    );

    // Bus source and load strobes decoded from the current step of the instruction.
    always_comb begin
        BusWires = '0;
        Done     = 1'b0;
        rx_wr    = 1'b0;
        a_ld     = 1'b0;
        g_ld     = 1'b0;
        case (state)
            T0: ;
            T1: begin
                case (op)
                    MV: begin
                        BusWires = regs[ry];
                        rx_wr    = 1'b1;
                        Done     = 1'b1;
                    end
                    MVI: begin
                        BusWires = DIN;
                        rx_wr    = 1'b1;
                        Done     = 1'b1;
                    end
                    ADD, SUB, AND, XOR: begin
                        BusWires = regs[rx];
                        a_ld     = 1'b1;
                    end
`ifdef PROC_MVNZ_EN
                    MVNZ: begin
                        BusWires = regs[ry];
                        rx_wr    = ~z_flag;
                        Done     = 1'b1;
                    end
`endif
                    default: Done = 1'b1;
                endcase
            end
            T2: begin
                BusWires = regs[ry];
                g_ld     = 1'b1;
            end
            T3: begin
                BusWires = g_reg;
                rx_wr    = 1'b1;
                Done     = 1'b1;
            end
            default: ;
        endcase
    end

`ifndef PROC_MVNZ_EN
    // Z is kept up to date even though nothing reads it in this build.
    logic z_unused;
    assign z_unused = z_flag;
`endif

    always_ff @(posedge clock or negedge aResetn) begin
        if (!aResetn) begin
            state  <= T0;
            ir     <= '0;
            a_reg  <= '0;
            g_reg  <= '0;
            z_flag <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (a_ld) a_reg <= BusWires;
            if (g_ld) begin
                g_reg  <= alu_res;
                z_flag <= alu_zero;
            end
            if (rx_wr) regs[rx] <= BusWires;
            case (state)
                T0: begin
                    if (Run) begin
                        ir    <= DIN;
                        state <= T1;
                    end
                end
                T1:      state <= is_alu(op) ? T2 : T0;
                T2:      state <= T3;
                T3:      state <= T0;
                default: state <= T0;
            endcase
        end
    end

endmodule

// File: tb/tb_processor_param.sv
// Randomised bench for processor_param: a per-instruction behavioural model predicts BusWires/Done for every cycle.
module tb_processor_param;

    localparam int DW = 9;
    localparam int RW = 3;

    logic          clock;
    logic          aResetn;
    logic          Run;
    logic [DW-1:0] DIN;
    logic          Done;
    logic [DW-1:0] BusWires;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] exp_bus  = '0;
    logic          exp_done = 1'b0;
    bit            exp_vld  = 1'b0;

    logic [DW-1:0] m_reg [8];
    logic          m_z;

    processor_param #(.DW(DW), .RW(RW)) dut (
        .clock    (clock),
        .aResetn  (aResetn),
        .Run      (Run),
        .DIN      (DIN),
        .Done     (Done),
        .BusWires (BusWires)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish, time=%0t required=below 2000000", $time);
        $fatal(1, "watchdog");
    end

    always @(negedge clock) begin
        if (exp_vld) begin
            checks++;
            if (BusWires !== exp_bus) begin
                errors++;
                $display("FAIL bus @%0t: got %h required %h", $time, BusWires, exp_bus);
            end
            checks++;
            if (Done !== exp_done) begin
                errors++;
                $display("FAIL done @%0t: got %b required %b", $time, Done, exp_done);
            end
        end
    end

    task automatic cyc(input logic [DW-1:0] b, input logic d);
        exp_bus  = b;
        exp_done = d;
        exp_vld  = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic lit(input string name, input int got, input int req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = '0;
        m_z = 1'b0;
    endtask

    function automatic logic [DW-1:0] alu(input int op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (op)
            2:       r = a + b;
            3:       r = a - b;
            4:       r = a & b;
            5:       r = a ^ b;
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic idle();
        Run = 1'b0;
        DIN = DW'($urandom);
        cyc('0, 1'b0);
    endtask

    task automatic exec(input int op, input int x, input int y, input logic [DW-1:0] imm, input bit keep);
        logic [DW-1:0] w;
        logic [DW-1:0] a;
        logic [DW-1:0] r;
        int            o;
        int            xx;
        int            yy;
        o  = op;
        xx = x;
        yy = y;
        w  = {o[2:0], xx[2:0], yy[2:0]};
        Run = 1'b1;
        DIN = w;
        cyc('0, 1'b0);
        Run = keep;
        DIN = DW'($urandom);
        case (op)
            0: begin
                cyc(m_reg[y], 1'b1);
                m_reg[x] = m_reg[y];
            end
            1: begin
                DIN = imm;
                cyc(imm, 1'b1);
                m_reg[x] = imm;
            end
            2, 3, 4, 5: begin
                a = m_reg[x];
                cyc(a, 1'b0);
                r = alu(op, a, m_reg[y]);
                cyc(m_reg[y], 1'b0);
                m_z = (r == '0);
                cyc(r, 1'b1);
                m_reg[x] = r;
            end
            6: begin
`ifdef PROC_MVNZ_EN
                cyc(m_reg[y], 1'b1);
                if (!m_z) m_reg[x] = m_reg[y];
`else
                cyc('0, 1'b1);
`endif
            end
            default: cyc('0, 1'b1);
        endcase
    endtask

    task automatic dump();
        for (int i = 0; i < 8; i++) exec(0, i, i, '0, 1'b0);
    endtask

    initial begin
        aResetn = 1'b0;
        Run     = 1'b0;
        DIN     = '0;
        model_reset();
        @(posedge clock);
        #1;
        cyc('0, 1'b0);
        cyc('0, 1'b0);
        aResetn = 1'b1;
        idle();
        idle();

        // Directed arithmetic sequence.
        exec(1, 0, 0, 9'd5, 1'b0);
        lit("mvi_r0_5", m_reg[0], 5);
        exec(1, 1, 0, 9'd3, 1'b0);
        exec(2, 0, 1, '0, 1'b0);
        lit("add_r0_8", m_reg[0], 8);
        lit("add_z0", m_z, 0);
        exec(3, 0, 0, '0, 1'b0);
        lit("sub_r0_0", m_reg[0], 0);
        lit("sub_z1", m_z, 1);
        exec(1, 0, 0, 9'h1FF, 1'b0);
        exec(1, 1, 0, 9'h001, 1'b0);
        exec(2, 0, 1, '0, 1'b0);
        lit("add_wrap", m_reg[0], 0);
        exec(1, 2, 0, 9'h0AA, 1'b0);
        exec(5, 2, 2, '0, 1'b0);
        lit("xor_self", m_reg[2], 0);

        // mvnz with Z=1 then Z=0.
        exec(1, 3, 0, 9'h011, 1'b0);
        exec(1, 1, 0, 9'h022, 1'b0);
        exec(6, 3, 1, '0, 1'b0);
        lit("mvnz_z1_keep", m_reg[3], 9'h011);
        exec(2, 1, 1, '0, 1'b0);
        lit("double_r1", m_reg[1], 9'h044);
        exec(6, 3, 1, '0, 1'b0);
`ifdef PROC_MVNZ_EN
        lit("mvnz_z0_move", m_reg[3], 9'h044);
`else
        lit("rsvd110_keep", m_reg[3], 9'h011);
`endif
        exec(0, 3, 3, '0, 1'b0);
        exec(1, 7, 0, 9'h0F0, 1'b0);
        exec(4, 7, 1, '0, 1'b0);
        lit("and_r7", m_reg[7], 9'h040);

        // Run held high across back-to-back moves, then Run low.
        exec(0, 4, 1, '0, 1'b1);
        exec(0, 5, 4, '0, 1'b1);
        exec(0, 6, 5, '0, 1'b1);
        lit("chain_r6", m_reg[6], 9'h044);
        idle();
        idle();
        idle();

        // Reset asserted during T2 of add aborts without a write.
        Run = 1'b1;
        DIN = {3'b010, 3'd6, 3'd1};
        cyc('0, 1'b0);
        Run = 1'b0;
        cyc(m_reg[6], 1'b0);
        aResetn = 1'b0;
        model_reset();
        cyc('0, 1'b0);
        cyc('0, 1'b0);
        aResetn = 1'b1;
        idle();
        dump();

        // Random instruction stream.
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) idle();
            exec($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                 DW'($urandom), 1'($urandom_range(0, 1)));
        end
        dump();
        idle();
        exp_vld = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
